// File: rtl/time_pkg.sv
// Shared time-of-day constants and BCD helpers, also used by the VGA
// digit-overlay stage.
// Contents: bcd_t digit type, per-digit maximums, hour limits, and
// tens_digit/units_digit helpers that split a binary value into BCD digits.
package time_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned MIN_TENS_MAX = 5;
  localparam int unsigned UNITS_MAX    = 9;
  localparam int unsigned HOUR_MAX_24  = 23;
  localparam int unsigned HOUR_MAX_12  = 12;

  // Tens digit of a binary value in the range 0..99.
  function automatic bcd_t tens_digit(input int unsigned v);
    return 4'((v / 10) % 10);
  endfunction

  // Units digit of a binary value in the range 0..99.
  function automatic bcd_t units_digit(input int unsigned v);
    return 4'(v % 10);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter with a configurable top value, a wrap value and a
// reset value.
// Ports:
//   clk_i, reset_i  clock and asynchronous active-high reset
//   clr_i           synchronous load of the reset value (takes priority)
//   inc_i           advance by one
//   tens_o, units_o registered BCD digits
//   carry_o_c       combinational: inc_i while the count is at MAX_VAL
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter int unsigned MAX_VAL   = 59,
  parameter int unsigned WRAP_VAL  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic inc_i,
  output bcd_t tens_o,
  output bcd_t units_o,
  output logic carry_o_c
);

  localparam bcd_t MAX_T   = tens_digit(MAX_VAL);
  localparam bcd_t MAX_U   = units_digit(MAX_VAL);
  localparam bcd_t WRAP_T  = tens_digit(WRAP_VAL);
  localparam bcd_t WRAP_U  = units_digit(WRAP_VAL);
  localparam bcd_t RST_T   = tens_digit(RESET_VAL);
  localparam bcd_t RST_U   = units_digit(RESET_VAL);
  localparam bcd_t U_LIMIT = 4'(UNITS_MAX);

  bcd_t tens_q, tens_d;
  bcd_t units_q, units_d;
  logic at_max_c;

  assign at_max_c  = (tens_q == MAX_T) && (units_q == MAX_U);
  assign carry_o_c = inc_i && at_max_c;

  // Next count: wrap at the top value, otherwise BCD increment.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr_i) begin
      tens_d  = RST_T;
      units_d = RST_U;
    end else if (inc_i) begin
      if (at_max_c) begin
        tens_d  = WRAP_T;
        units_d = WRAP_U;
      end else if (units_q == U_LIMIT) begin
        tens_d  = tens_q + 4'd1;
        units_d = 4'd0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tens_q  <= RST_T;
      units_q <= RST_U;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens_o  = tens_q;
  assign units_o = units_q;

endmodule

// File: rtl/bcd_time_counter.sv
// Time-of-day counter driving six BCD digits HH:MM:SS for the VGA overlay,
// with a 1 Hz prescaler from the pixel clock and a set mode with hour and
// minute increment buttons.
// Build option: define CLOCK_12H_EN for a 12-hour clock (12,01..11) with a
// pm output; without it the clock runs 00..23.
// Ports:
//   clk               pixel clock
//   reset             asynchronous active-high reset
//   set_mode          async level, 1 = time-setting mode
//   inc_h, inc_m      async buttons, each rising edge adds an hour/minute
//   h1,h0,m1,m0,s1,s0 registered BCD digits
//   tick              one-clock pulse on each second advance
//   pm                (CLOCK_12H_EN only) toggles on 11 -> 12
module bcd_time_counter
  import time_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 25000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_mode,
  input  logic       inc_h,
  input  logic       inc_m,
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       tick
`ifdef CLOCK_12H_EN
  ,
  output logic       pm
`endif
);

  localparam int unsigned PRE_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(CLK_HZ - 1);

`ifdef CLOCK_12H_EN
  localparam int unsigned HR_MAX  = HOUR_MAX_12;
  localparam int unsigned HR_WRAP = 1;
  localparam int unsigned HR_RST  = HOUR_MAX_12;
`else
  localparam int unsigned HR_MAX  = HOUR_MAX_24;
  localparam int unsigned HR_WRAP = 0;
  localparam int unsigned HR_RST  = 0;
`endif

  localparam int unsigned SEC_MAX = SEC_TENS_MAX * 10 + UNITS_MAX;
  localparam int unsigned MIN_MAX = MIN_TENS_MAX * 10 + UNITS_MAX;

  // Input synchronizers; the top bit is the synchronized level.
  logic [SYNC_STAGES-1:0] sm_sync_q, h_sync_q, m_sync_q;
  logic                   h_prev_q, m_prev_q;
  logic                   set_mode_s, h_s, m_s;
  logic                   h_edge_c, m_edge_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sm_sync_q <= '0;
      h_sync_q  <= '0;
      m_sync_q  <= '0;
      h_prev_q  <= 1'b0;
      m_prev_q  <= 1'b0;
    end else begin
      sm_sync_q <= {sm_sync_q[SYNC_STAGES-2:0], set_mode};
      h_sync_q  <= {h_sync_q[SYNC_STAGES-2:0], inc_h};
      m_sync_q  <= {m_sync_q[SYNC_STAGES-2:0], inc_m};
      h_prev_q  <= h_s;
      m_prev_q  <= m_s;
    end
  end

  assign set_mode_s = sm_sync_q[SYNC_STAGES-1];
  assign h_s        = h_sync_q[SYNC_STAGES-1];
  assign m_s        = m_sync_q[SYNC_STAGES-1];
  // Buttons only count while in set mode.
  assign h_edge_c   = set_mode_s && h_s && !h_prev_q;
  assign m_edge_c   = set_mode_s && m_s && !m_prev_q;

  // 1 Hz prescaler; held at zero in set mode so leaving it restarts a full second.
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (set_mode_s) begin
      presc_d = '0;
    end else if (presc_q == PRE_TERM) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

  // Carry chain, all resolved within one cycle. Set mode breaks the chain
  // so minute increments never carry into hours.
  logic sec_carry_c, min_carry_c, hr_carry_unused;
  logic min_inc_c, hr_inc_c;

  assign min_inc_c = set_mode_s ? m_edge_c : sec_carry_c;
  assign hr_inc_c  = set_mode_s ? h_edge_c : min_carry_c;

  bcd_mod_counter #(
    .MAX_VAL  (SEC_MAX),
    .WRAP_VAL (0),
    .RESET_VAL(0)
  ) u_sec (
    .clk_i    (clk),
    .reset_i  (reset),
    .clr_i    (set_mode_s),
    .inc_i    (tick_d),
    .tens_o   (s1),
    .units_o  (s0),
    .carry_o_c(sec_carry_c)
  );

  bcd_mod_counter #(
    .MAX_VAL  (MIN_MAX),
    .WRAP_VAL (0),
    .RESET_VAL(0)
  ) u_min (
    .clk_i    (clk),
    .reset_i  (reset),
    .clr_i    (1'b0),
    .inc_i    (min_inc_c),
    .tens_o   (m1),
    .units_o  (m0),
    .carry_o_c(min_carry_c)
  );

  bcd_mod_counter #(
    .MAX_VAL  (HR_MAX),
    .WRAP_VAL (HR_WRAP),
    .RESET_VAL(HR_RST)
  ) u_hr (
    .clk_i    (clk),
    .reset_i  (reset),
    .clr_i    (1'b0),
    .inc_i    (hr_inc_c),
    .tens_o   (h1),
    .units_o  (h0),
    .carry_o_c(hr_carry_unused)
  );

`ifdef CLOCK_12H_EN
  // pm flips whenever the hour steps from 11 to 12, in run or set mode.
  logic pm_q, pm_d;

  always_comb begin
    pm_d = pm_q;
    if (hr_inc_c && (h1 == 4'd1) && (h0 == 4'd1)) begin
      pm_d = !pm_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pm_q <= 1'b0;
    end else begin
      pm_q <= pm_d;
    end
  end

  assign pm = pm_q;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter with CLK_HZ=4 (one second = 4 clocks).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_bcd_time_counter;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       set_mode = 1'b0;
  logic       inc_h    = 1'b0;
  logic       inc_m    = 1'b0;
  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic       tick;
`ifdef CLOCK_12H_EN
  logic       pm;
  localparam logic [23:0] RST_T = 24'h120000;
`else
  localparam logic [23:0] RST_T = 24'h000000;
`endif

  int n_checks  = 0;
  int n_pass    = 0;
  int tick_seen = 0;
  int n_tk;

  always #5 clk = ~clk;

  bcd_time_counter #(
    .CLK_HZ     (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .set_mode(set_mode),
    .inc_h   (inc_h),
    .inc_m   (inc_m),
    .h1      (h1),
    .h0      (h0),
    .m1      (m1),
    .m0      (m0),
    .s1      (s1),
    .s0      (s0),
    .tick    (tick)
`ifdef CLOCK_12H_EN
    ,
    .pm      (pm)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] now_t();
    return {8'h00, h1, h0, m1, m0, s1, s0};
  endfunction

  // Advance n clocks, sampling 1 unit after each edge and counting ticks.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tick) tick_seen++;
    end
  endtask

  // One button press: 2 clocks high, 2 clocks low.
  task automatic press(input logic h, input logic m);
    inc_h = h;
    inc_m = m;
    step(2);
    inc_h = 1'b0;
    inc_m = 1'b0;
    step(2);
  endtask

  initial begin
    // Reset state and first second after release.
    step(2);
    check("reset_time", now_t(), {8'h00, RST_T});
    check("reset_tick", 32'(tick), 32'd0);
`ifdef CLOCK_12H_EN
    check("reset_pm", 32'(pm), 32'd0);
`endif
    reset = 1'b0;
    step(3);
    check("pre_tick", 32'(tick), 32'd0);
    step(1);
    check("first_tick", 32'(tick), 32'd1);
    check("first_sec", now_t(), {8'h00, RST_T + 24'h1});
    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    check("async_rst_time", now_t(), {8'h00, RST_T});
    check("async_rst_tick", 32'(tick), 32'd0);
    step(1);
    reset = 1'b0;

`ifdef CLOCK_12H_EN
    // Set 11:59, then run into 12:00:00 with pm toggling.
    set_mode = 1'b1;
    step(3);
    for (int i = 0; i < 11; i++) press(1'b1, 1'b0);
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
    check("set_1159", now_t(), 32'h00115900);
    check("set_pm", 32'(pm), 32'd0);
    set_mode = 1'b0;
    step(2);
    step(4 * 59);
    check("run_115959", now_t(), 32'h00115959);
    check("pm_before", 32'(pm), 32'd0);
    step(4);
    check("run_120000", now_t(), 32'h00120000);
    check("pm_toggle", 32'(pm), 32'd1);
    // 12:59:59 -> 01:00:00 keeps pm.
    set_mode = 1'b1;
    step(3);
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
    check("set_1259", now_t(), 32'h00125900);
    set_mode = 1'b0;
    step(2);
    step(4 * 59);
    check("run_125959", now_t(), 32'h00125959);
    step(4);
    check("run_010000", now_t(), 32'h00010000);
    check("pm_kept", 32'(pm), 32'd1);
`else
    // Set 23:59 in set mode, run to 23:59:58, then across midnight.
    set_mode = 1'b1;
    step(3);
    for (int i = 0; i < 23; i++) press(1'b1, 1'b0);
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
    check("set_2359", now_t(), 32'h00235900);
    set_mode = 1'b0;
    step(2);
    step(4 * 58);
    check("run_235958", now_t(), 32'h00235958);
    check("tick_235958", 32'(tick), 32'd1);
    n_tk = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (tick) n_tk++;
      if (i == 4) check("run_235959", now_t(), 32'h00235959);
      if (i == 8) check("midnight", now_t(), 32'h00000000);
    end
    check("rollover_ticks", 32'(n_tk), 32'd2);

    // Set mode at 00:00:37 clears seconds; 61 minute presses give 00:01.
    step(4 * 37);
    check("run_000037", now_t(), 32'h00000037);
    set_mode  = 1'b1;
    tick_seen = 0;
    step(3);
    check("set_clr_sec", now_t(), 32'h00000000);
    for (int i = 0; i < 61; i++) press(1'b0, 1'b1);
    check("min_mod60", now_t(), 32'h00000100);
    check("set_no_tick", 32'(tick_seen), 32'd0);

    // Simultaneous buttons: applied together two edges after sampling.
    inc_h = 1'b1;
    inc_m = 1'b1;
    step(1);
    check("lat_k", now_t(), 32'h00000100);
    step(1);
    check("lat_k1", now_t(), 32'h00000100);
    step(1);
    check("lat_k2", now_t(), 32'h00010200);
    step(7);
    check("held_once", now_t(), 32'h00010200);
    inc_h = 1'b0;
    inc_m = 1'b0;
    step(4);
    check("released", now_t(), 32'h00010200);

    // Buttons ignored outside set mode.
    set_mode = 1'b0;
    step(3);
    press(1'b1, 1'b0);
    check("ign_inc_h", 32'({h1, h0}), 32'h01);
    check("ign_min", 32'({m1, m0}), 32'h02);

    // Button held through reset release does not count.
    inc_m = 1'b1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(4);
    check("rst_held_m", now_t(), 32'h00000001);
    step(4);
    check("rst_held_m2", now_t(), 32'h00000002);
    inc_m = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
